// File: rtl/vga_sync_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_tracker_if
//  Description : Sync bundle (hsync, vsync, display_on) feeding the tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_sync_tracker_if;
    logic hsync;
    logic vsync;
    logic display_on;

    modport master (output hsync, output vsync, output display_on);
    modport slave  (input  hsync, input  vsync, input  display_on);
endinterface
`default_nettype wire

// File: rtl/vga_sync_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_tracker
//  Description : Measures hsync/vsync timing and declares lock on a matching
//                grid; optional mismatch counter under VGA_TRACK_ERRCNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_tracker #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int LOCK_FRAMES = 2
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    vga_sync_tracker_if.slave   sync_if,
    output logic                locked,
    output logic                frame_tick,
    output logic [9:0]          h_total_meas,
    output logic [9:0]          h_sync_meas,
    output logic [9:0]          v_total_meas,
    output logic [9:0]          v_sync_meas,
    output logic [7:0]          err_count
);

    localparam logic [9:0] c_h_total   = 10'(H_TOTAL);
    localparam logic [9:0] c_h_sync    = 10'(H_SYNC);
    localparam logic [9:0] c_v_total   = 10'(V_TOTAL);
    localparam logic [9:0] c_v_sync    = 10'(V_SYNC);
    localparam logic [9:0] c_h_timeout = 10'(H_TOTAL + 1);
    localparam logic [9:0] c_cnt_max   = 10'h3FF;
    localparam logic [3:0] c_lock      = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t     r_state, w_state_next;
    logic [3:0] r_good_cnt, w_good_next;
    logic       r_hs_d, r_vs_d;
    logic [9:0] r_h_cnt, r_v_cnt, r_vs_cnt;
    logic       r_h_valid, r_frame_err;

    logic       w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall;
    logic [9:0] w_h_inc, w_v_inc, w_vs_inc, w_v_total_cap;
    logic       w_line_bad, w_width_bad, w_frame_bad, w_vwidth_bad;
    logic       w_timeout, w_de_bad, w_mismatch;

    assign w_hs_rise = sync_if.hsync & ~r_hs_d;
    assign w_hs_fall = ~sync_if.hsync & r_hs_d;
    assign w_vs_rise = sync_if.vsync & ~r_vs_d;
    assign w_vs_fall = ~sync_if.vsync & r_vs_d;

    assign w_h_inc  = (r_h_cnt  == c_cnt_max) ? c_cnt_max : r_h_cnt  + 10'd1;
    assign w_v_inc  = (r_v_cnt  == c_cnt_max) ? c_cnt_max : r_v_cnt  + 10'd1;
    assign w_vs_inc = (r_vs_cnt == c_cnt_max) ? c_cnt_max : r_vs_cnt + 10'd1;

    // A coincident hsync rise belongs to the frame that is ending.
    assign w_v_total_cap = w_hs_rise ? w_v_inc : r_v_cnt;

    assign w_line_bad   = w_hs_rise & r_h_valid & (w_h_inc != c_h_total);
    assign w_width_bad  = w_hs_fall & (w_h_inc != c_h_sync);
    assign w_frame_bad  = w_vs_rise & (w_v_total_cap != c_v_total);
    assign w_vwidth_bad = w_vs_fall & (r_vs_cnt != c_v_sync);
    assign w_timeout    = r_h_valid & ~w_hs_rise & (r_h_cnt == c_h_timeout);
    assign w_de_bad     = (r_state == ST_LOCKED) & sync_if.display_on &
                          (sync_if.hsync | sync_if.vsync);
    assign w_mismatch   = w_line_bad | w_width_bad | w_frame_bad |
                          w_vwidth_bad | w_timeout | w_de_bad;

    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good_cnt;
        case (r_state)
            ST_SEARCH: begin
                if (w_vs_rise) begin
                    w_state_next = ST_TRACK;
                    w_good_next  = 4'd0;
                end
            end
            ST_TRACK: begin
                if (w_vs_rise) begin
                    if (!r_frame_err && !w_mismatch) begin
                        w_good_next = r_good_cnt + 4'd1;
                        if (r_good_cnt + 4'd1 == c_lock) begin
                            w_state_next = ST_LOCKED;
                        end
                    end else begin
                        w_good_next = 4'd0;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_mismatch) begin
                    w_state_next = ST_TRACK;
                    w_good_next  = 4'd0;
                end
            end
            default: begin
                w_state_next = ST_SEARCH;
                w_good_next  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_SEARCH;
            r_good_cnt   <= 4'd0;
            r_hs_d       <= 1'b0;
            r_vs_d       <= 1'b0;
            r_h_cnt      <= 10'd0;
            r_v_cnt      <= 10'd0;
            r_vs_cnt     <= 10'd0;
            r_h_valid    <= 1'b0;
            r_frame_err  <= 1'b0;
            locked       <= 1'b0;
            frame_tick   <= 1'b0;
            h_total_meas <= 10'd0;
            h_sync_meas  <= 10'd0;
            v_total_meas <= 10'd0;
            v_sync_meas  <= 10'd0;
        end else begin
            r_hs_d     <= sync_if.hsync;
            r_vs_d     <= sync_if.vsync;
            r_state    <= w_state_next;
            r_good_cnt <= w_good_next;
            locked     <= (w_state_next == ST_LOCKED);
            frame_tick <= w_vs_rise;

            if (w_hs_rise) begin
                r_h_cnt <= 10'd0;
                if (r_h_valid) h_total_meas <= w_h_inc;
            end else begin
                r_h_cnt <= w_h_inc;
            end
            if (w_hs_fall) h_sync_meas <= w_h_inc;

            // Entering TRACK discards the line in progress.
            if (r_state == ST_SEARCH && w_vs_rise) r_h_valid <= 1'b0;
            else if (w_hs_rise)                    r_h_valid <= 1'b1;

            if (w_vs_rise) begin
                v_total_meas <= w_v_total_cap;
                r_v_cnt      <= 10'd0;
            end else if (w_hs_rise) begin
                r_v_cnt      <= w_v_inc;
            end

            if (w_vs_rise)                          r_vs_cnt <= {9'd0, w_hs_rise};
            else if (w_hs_rise && sync_if.vsync)    r_vs_cnt <= w_vs_inc;
            if (w_vs_fall) v_sync_meas <= r_vs_cnt;

            if (w_vs_rise)       r_frame_err <= 1'b0;
            else if (w_mismatch) r_frame_err <= 1'b1;
        end
    end

`ifdef VGA_TRACK_ERRCNT_EN
    logic [7:0] r_err_cnt;
    logic       w_err_count_en;

    assign w_err_count_en = w_mismatch &
                            ((r_state == ST_LOCKED) ||
                             (r_state == ST_TRACK && r_good_cnt != 4'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_err_count_en && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: doc/vga_sync_tracker.md
Name: vga_sync_tracker

Overview:
- Receive-side companion to the VGA grid timing generator. Consumes registered hsync/vsync/display_on and measures line period, hsync width, frame height and vsync width.
- Declares lock once consecutive frames match the 640x480@60 grid timing.
- Used as a built-in self-check on the sync outputs, and as a timing monitor where sync arrives from another same-clock source.

Parameters:
- H_TOTAL, 800, expected clocks per line (rising hsync to rising hsync)
- H_SYNC, 96, expected hsync high width in clocks
- V_TOTAL, 525, expected lines per frame (hsync rising edges between vsync rising edges)
- V_SYNC, 2, expected vsync high width in lines (hsync rising edges while vsync high)
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hsync  in  1  horizontal sync, active high, synchronous to clk
- vsync  in  1  vertical sync, active high, synchronous to clk
- display_on  in  1  visible-area flag; monitored only in LOCKED
- locked  out  1  timing matches parameters
- frame_tick  out  1  one-cycle pulse, cycle after each detected vsync rising edge
- h_total_meas  out  10  last measured line period, clocks
- h_sync_meas  out  10  last measured hsync width, clocks
- v_total_meas  out  10  last measured frame height, lines
- v_sync_meas  out  10  last measured vsync width, lines
- err_count  out  8  saturating mismatch counter (see Optional Feature)

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low. All outputs are 0 in reset, state is SEARCH, and all internal counters are 0.
- Edge detect: one-cycle-delayed copies of hsync and vsync. An edge is registered the cycle after the input changes.
- h counter (10 bit, saturating at 1023):
  - increments every cycle;
  - on hsync rise: if h_valid, capture count+1 into h_total_meas; then reload to 0 and set h_valid;
  - on hsync fall: capture count+1 into h_sync_meas.
- v line counter (10 bit, saturating): increments on each hsync rise. On vsync rise: capture into v_total_meas, then reload to 0.
- vsync width counter: counts hsync rises while vsync is high; captured into v_sync_meas on vsync fall.
- Checks:
  - line check on each hsync rise with h_valid: h_total_meas must equal H_TOTAL;
  - width check on hsync fall: must equal H_SYNC;
  - frame check on vsync rise: V_TOTAL; on vsync fall: V_SYNC;
  - timeout: h counter reaching H_TOTAL+1 without an hsync rise is a mismatch, flagged once per line.
- Any failed check sets the sticky frame_err. frame_err is cleared at each vsync rise, after being evaluated.
- FSM:
  - SEARCH: wait for a vsync rise, then go to TRACK. good_cnt=0, frame_err cleared, h_valid cleared (the first partial line is ignored).
  - TRACK, on vsync rise: if frame_err=0 and the V_TOTAL check passes, good_cnt++, and on reaching LOCK_FRAMES go to LOCKED. Otherwise good_cnt=0.
  - LOCKED: any mismatch (line, width, frame or timeout) returns to TRACK with good_cnt=0. locked deasserts the cycle after the failing check.
  - LOCKED additionally: display_on high while hsync or vsync is high counts as a mismatch.
- locked is high iff state is LOCKED (registered).
- Simultaneous hsync and vsync rises in the same cycle: the hsync rise is counted into the line count before the vsync capture.
- Measurement outputs hold their last value through loss of lock. They update regardless of state.

Optional Feature:
- Macro: VGA_TRACK_ERRCNT_EN.
- Defined: err_count increments by 1 on every mismatch event while in LOCKED, or while in TRACK with good_cnt>0. It saturates at 255 and is cleared only by reset.
- Undefined: err_count is tied to 0 and no counter logic is built.

Test Plan:
- Drive the nominal grid generator timing from reset -> frame_tick on each vsync rise; locked rises the cycle after the 3rd vsync rise; h_total_meas=800, h_sync_meas=96, v_total_meas=525, v_sync_meas=2; err_count=0.
- While locked, stretch one line to 801 clocks -> locked falls; err_count=1; relock after 2 further clean frames.
- While locked, hold hsync low -> mismatch when h counter hits 801; locked=0; h counter saturates at 1023 with no wrap.
- Frame with vsync high for 3 lines -> mismatch at vsync fall; v_sync_meas=3; good_cnt reset; no lock from that frame.
- Assert rst_n low mid-frame while locked -> all outputs 0 immediately (async); after release, lock again after the 3rd vsync rise.
- Inject 300 mismatches with VGA_TRACK_ERRCNT_EN defined -> err_count saturates at 255; same stimulus with the macro undefined -> err_count stays 0.
